pattern_multi_snake: RTL and testbench
======================================

# pattern_multi_snake

Multi-snake pattern generator for the MAX7219 framebuffer display chain. NUM_SNAKES independent diagonal snakes move across a DISP_ROWS x DISP_COLUMNS grid of 8x8 matrices. Each snake has a fixed visible length, and the block supports either bouncing off or wrapping around the edges. It drives the same 8-stream MAX7219 data bus as the other pattern generators and plugs into the MAX7219 framebuffer driver unchanged.

## Interface
- DISP_ROWS, 1, number of 8x8 matrices vertically
- DISP_COLUMNS, 1, number of 8x8 matrices horizontally
- DELAY_CLOCKS, 60000, idle clocks between steps (5 ms at 12 MHz)
- NUM_SNAKES, 2, number of snakes, 1..8
- TAIL_LENGTH, 4, lit pixels per snake = TAIL_LENGTH+1, at least 1
- EDGE_MODE, EDGE_BOUNCE, edge behaviour: EDGE_BOUNCE or EDGE_WRAP
- i_Clk  in  1  single clock; all logic on the rising edge
- i_Rst  in  1  reset, synchronous, active-high
- i_Pause  in  1  freezes stepping while high
- o_Step  out  1  one-cycle pulse when a step's framebuffer update is complete
- o_MAX7219_DataStream  out  [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0]  per-row MAX7219 words

## Operation
- Framebuffer fb is FB_HEIGHT=DISP_ROWS*8 rows by FB_WIDTH=DISP_COLUMNS*8 columns, 1 bit per pixel.
- Output mapping is combinational from fb: stream [7-s][r][c] = {HDR, REG_ROW(s), fb[r*8+7-s][c*8+7 .. c*8+0]}, with the MSB word bit equal to column c*8+7.
- Per-snake state:
  - head x ($clog2(FB_WIDTH) bits) and head y ($clog2(FB_HEIGHT) bits);
  - direction bits x_right and y_up;
  - history shift register of TAIL_LENGTH+1 plotted positions;
  - fill count saturating at TAIL_LENGTH+1.
- Reset values:
  - fb all 0;
  - snake k head = ((3*k) mod FB_WIDTH, k mod FB_HEIGHT);
  - x_right = 1 for even k, 0 for odd k; y_up = 1;
  - history contents don't-care, fill count 0;
  - state WAIT, delay counter 0, o_Step 0.
- FSM states:
  - WAIT: the counter increments each cycle unless i_Pause is high, in which case it holds. When counter == DELAY_CLOCKS, go to ERASE with k=0.
  - ERASE (NUM_SNAKES cycles): for snake k, if fill == TAIL_LENGTH+1, clear fb at its oldest history entry.
  - PLOT (NUM_SNAKES cycles): for snake k, set fb at the head, shift the head into history, increment fill if not saturated, then advance the head. After k=NUM_SNAKES-1, go to WAIT with counter 0 and o_Step high for that first WAIT cycle.
- All erases precede all plots within a step, so a live head always wins a pixel another snake's tail vacates. Another snake's tail may still erase a body pixel; that is accepted behaviour.
- No erase happens before the history is full, so there are no spurious clears at (0,0).
- Head advance, per axis, EDGE_BOUNCE:
  - at max index: direction becomes decreasing, coordinate minus 1;
  - at 0: direction becomes increasing, coordinate plus 1;
  - otherwise: step by direction.
- Head advance, per axis, EDGE_WRAP: step by direction modulo the dimension; direction never changes.
- Indices are computed at full width, then compared against FB_WIDTH-1 and FB_HEIGHT-1. Non-power-of-two widths never index past the framebuffer.
- i_Pause is only honoured in WAIT; a step already in ERASE/PLOT completes.
- i_Rst mid-step aborts the step and restores all reset values on the next edge. Partial fb writes are discarded because fb is cleared.

## Timing
- Step period = DELAY_CLOCKS+1+2*NUM_SNAKES cycles when not paused.
- The first ERASE cycle occurs DELAY_CLOCKS+1 cycles after the first clock edge with i_Rst low.
- An fb write in a PLOT or ERASE cycle is visible on o_MAX7219_DataStream the following cycle.
- o_Step coincides with the first cycle in which the full step is visible.

## Structure
- max7219_types already holds HDR and REG_ROW_0..7.
- Add edge_mode_t {EDGE_BOUNCE, EDGE_WRAP} to max7219_types.
- Sub-module snake_walker: holds one snake's head, direction, history and fill count. It takes a start position/direction, an advance strobe, and EDGE_MODE/size parameters. It exposes head, tail, and tail_valid.
- The top level keeps fb, the FSM, the delay counter and the output mapping, and instantiates NUM_SNAKES snake_walker instances.

## Test plan
- 1x1 grid, NUM_SNAKES=1, TAIL_LENGTH=2, DELAY_CLOCKS=3, bounce:
  - after reset all outputs are {HDR, REG_ROW(s), 8'h00}, o_Step=0;
  - steps 1-3 light (0,0), (1,1), (2,2);
  - step 4 lights (3,3) and clears (0,0), leaving exactly 3 pixels lit.
- Bounce corner, 8x8: head at (7,7) moving +/+ -> next plot at (6,6), directions both decreasing; from (0,0) -> (1,1).
- Wrap, 8x8: head at (7,7) moving +/+ -> next plot at (0,0); pixels (7,7) and (0,0) are both lit at once.
- NUM_SNAKES=2, 2x1 grid, DELAY_CLOCKS=5: o_Step period equals 10 cycles. One snake's tail erase onto the other's head pixel in the same step leaves that pixel lit.
- i_Pause held high for 20 cycles in WAIT: the counter freezes, no fb change, no o_Step; stepping resumes with the same remaining count.
- i_Rst asserted in the second PLOT cycle: the next cycle shows fb all zero, heads at their start positions, state WAIT, o_Step 0.

Source files
------------

// File: rtl/pattern_multi_snake_pkg.sv
// Shared MAX7219 word fields, edge/FSM enums and the per-axis head-step helpers
// used by the pattern generators.
package max7219_types;

    localparam logic [3:0] HDR       = 4'h0;
    localparam logic [3:0] REG_ROW_0 = 4'h1;
    localparam logic [3:0] REG_ROW_1 = 4'h2;
    localparam logic [3:0] REG_ROW_2 = 4'h3;
    localparam logic [3:0] REG_ROW_3 = 4'h4;
    localparam logic [3:0] REG_ROW_4 = 4'h5;
    localparam logic [3:0] REG_ROW_5 = 4'h6;
    localparam logic [3:0] REG_ROW_6 = 4'h7;
    localparam logic [3:0] REG_ROW_7 = 4'h8;

    typedef enum logic {
        EDGE_BOUNCE,
        EDGE_WRAP
    } edge_mode_t;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_ERASE,
        ST_PLOT
    } snake_state_t;

    function automatic logic [3:0] reg_row(input int unsigned s);
        case (s)
            0:       reg_row = REG_ROW_0;
            1:       reg_row = REG_ROW_1;
            2:       reg_row = REG_ROW_2;
            3:       reg_row = REG_ROW_3;
            4:       reg_row = REG_ROW_4;
            5:       reg_row = REG_ROW_5;
            6:       reg_row = REG_ROW_6;
            default: reg_row = REG_ROW_7;
        endcase
    endfunction

    // Coordinates are stepped at 32 bits and compared against size-1 so that
    // non-power-of-two dimensions never produce an out-of-range index.
    function automatic logic [31:0] axis_next_pos(input logic [31:0] pos, input logic inc,
                                                  input logic [31:0] size, input edge_mode_t mode);
        if (mode == EDGE_WRAP) begin
            if (inc) axis_next_pos = (pos == size - 1) ? 32'd0 : pos + 1;
            else     axis_next_pos = (pos == 32'd0) ? size - 1 : pos - 1;
        end else begin
            if (pos == size - 1)  axis_next_pos = pos - 1;
            else if (pos == 32'd0) axis_next_pos = pos + 1;
            else                  axis_next_pos = inc ? pos + 1 : pos - 1;
        end
    endfunction

    function automatic logic axis_next_inc(input logic [31:0] pos, input logic inc,
                                           input logic [31:0] size, input edge_mode_t mode);
        if (mode == EDGE_WRAP)     axis_next_inc = inc;
        else if (pos == size - 1)  axis_next_inc = 1'b0;
        else if (pos == 32'd0)     axis_next_inc = 1'b1;
        else                       axis_next_inc = inc;
    endfunction

endpackage

// File: rtl/pattern_multi_snake_walker.sv
// One snake: head position and direction, plus a shift register of the last
// TAIL_LENGTH+1 plotted positions so the oldest one can be erased.
module snake_walker
    import max7219_types::*;
#(
    parameter int unsigned FB_WIDTH    = 8,
    parameter int unsigned FB_HEIGHT   = 8,
    parameter int unsigned TAIL_LENGTH = 4,
    parameter edge_mode_t  EDGE_MODE   = EDGE_BOUNCE,
    localparam int unsigned XW = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1,
    localparam int unsigned YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [XW-1:0] start_x_i,
    input  logic [YW-1:0] start_y_i,
    input  logic          start_x_right_i,
    input  logic          start_y_up_i,
    input  logic          advance_i,
    output logic [XW-1:0] head_x_o,
    output logic [YW-1:0] head_y_o,
    output logic [XW-1:0] tail_x_o,
    output logic [YW-1:0] tail_y_o,
    output logic          tail_valid_o
);

    localparam int unsigned   FW       = $clog2(TAIL_LENGTH + 2);
    localparam logic [FW-1:0] FILL_MAX = FW'(TAIL_LENGTH + 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          xr_q, xr_d;
    logic          yu_q, yu_d;
    logic [FW-1:0] fill_q;
    logic [TAIL_LENGTH:0][XW+YW-1:0] hist_q;

    always_comb begin
        x_d  = XW'(axis_next_pos(32'(x_q), xr_q, FB_WIDTH, EDGE_MODE));
        xr_d = axis_next_inc(32'(x_q), xr_q, FB_WIDTH, EDGE_MODE);
        y_d  = YW'(axis_next_pos(32'(y_q), yu_q, FB_HEIGHT, EDGE_MODE));
        yu_d = axis_next_inc(32'(y_q), yu_q, FB_HEIGHT, EDGE_MODE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q    <= start_x_i;
            y_q    <= start_y_i;
            xr_q   <= start_x_right_i;
            yu_q   <= start_y_up_i;
            fill_q <= '0;
        end else if (advance_i) begin
            x_q  <= x_d;
            y_q  <= y_d;
            xr_q <= xr_d;
            yu_q <= yu_d;
            if (fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
        end
    end

    // History contents are only meaningful once fill_q saturates, so no reset.
    if (TAIL_LENGTH == 0) begin : g_hist_one
        always_ff @(posedge clk_i) begin
            if (advance_i) hist_q[0] <= {x_q, y_q};
        end
    end else begin : g_hist_shift
        always_ff @(posedge clk_i) begin
            if (advance_i) hist_q <= {hist_q[TAIL_LENGTH-1:0], {x_q, y_q}};
        end
    end

    assign head_x_o     = x_q;
    assign head_y_o     = y_q;
    assign tail_x_o     = hist_q[TAIL_LENGTH][XW+YW-1:YW];
    assign tail_y_o     = hist_q[TAIL_LENGTH][YW-1:0];
    assign tail_valid_o = (fill_q == FILL_MAX);

endmodule

// File: rtl/pattern_multi_snake.sv
// Multi-snake diagonal pattern generator: owns the framebuffer, step FSM and
// delay counter, and maps the framebuffer onto the 8-stream MAX7219 bus.
module pattern_multi_snake
    import max7219_types::*;
#(
    parameter int unsigned DISP_ROWS    = 1,
    parameter int unsigned DISP_COLUMNS = 1,
    parameter int unsigned DELAY_CLOCKS = 60000,
    parameter int unsigned NUM_SNAKES   = 2,
    parameter int unsigned TAIL_LENGTH  = 4,
    parameter edge_mode_t  EDGE_MODE    = EDGE_BOUNCE
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Pause,
    output logic o_Step,
    output logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] o_MAX7219_DataStream
);

    localparam int unsigned FB_W  = DISP_COLUMNS * 8;
    localparam int unsigned FB_H  = DISP_ROWS * 8;
    localparam int unsigned XW    = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int unsigned YW    = (FB_H > 1) ? $clog2(FB_H) : 1;
    localparam int unsigned PW    = $clog2(FB_W * FB_H);
    localparam int unsigned CNT_W = $clog2(DELAY_CLOCKS + 2);
    localparam int unsigned KW    = (NUM_SNAKES > 1) ? $clog2(NUM_SNAKES) : 1;

    snake_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [KW-1:0]     k_q, k_d;
    logic              step_q, step_d;
    logic [FB_W*FB_H-1:0] fb_q;

    logic [XW-1:0] head_x [NUM_SNAKES];
    logic [YW-1:0] head_y [NUM_SNAKES];
    logic [XW-1:0] tail_x [NUM_SNAKES];
    logic [YW-1:0] tail_y [NUM_SNAKES];
    logic [NUM_SNAKES-1:0] tail_valid;
    logic [NUM_SNAKES-1:0] adv;

    logic          wr_en;
    logic          wr_val;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [PW-1:0] wr_idx;

    for (genvar i = 0; i < NUM_SNAKES; i++) begin : g_snake
        assign adv[i] = (state_q == ST_PLOT) && (k_q == KW'(i));

        snake_walker #(
            .FB_WIDTH    (FB_W),
            .FB_HEIGHT   (FB_H),
            .TAIL_LENGTH (TAIL_LENGTH),
            .EDGE_MODE   (EDGE_MODE)
        ) u_walker (
            .clk_i           (i_Clk),
            .rst_i           (i_Rst),
            .start_x_i       (XW'((3 * i) % FB_W)),
            .start_y_i       (YW'(i % FB_H)),
            .start_x_right_i ((i % 2) == 0),
            .start_y_up_i    (1'b1),
            .advance_i       (adv[i]),
            .head_x_o        (head_x[i]),
            .head_y_o        (head_y[i]),
            .tail_x_o        (tail_x[i]),
            .tail_y_o        (tail_y[i]),
            .tail_valid_o    (tail_valid[i])
        );
    end

    // All erases of a step run before any plot, so a head always wins a pixel
    // vacated in the same step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        step_d  = 1'b0;
        wr_en   = 1'b0;
        wr_val  = 1'b0;
        wr_x    = '0;
        wr_y    = '0;
        case (state_q)
            ST_WAIT: begin
                if (!i_Pause) begin
                    if (cnt_q == CNT_W'(DELAY_CLOCKS)) begin
                        state_d = ST_ERASE;
                        k_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ERASE: begin
                wr_en  = tail_valid[k_q];
                wr_val = 1'b0;
                wr_x   = tail_x[k_q];
                wr_y   = tail_y[k_q];
                if (k_q == KW'(NUM_SNAKES - 1)) begin
                    state_d = ST_PLOT;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_PLOT: begin
                wr_en  = 1'b1;
                wr_val = 1'b1;
                wr_x   = head_x[k_q];
                wr_y   = head_y[k_q];
                if (k_q == KW'(NUM_SNAKES - 1)) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    k_d     = '0;
                    step_d  = 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    assign wr_idx = PW'(wr_y) * PW'(FB_W) + PW'(wr_x);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            k_q     <= '0;
            step_q  <= 1'b0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            step_q  <= step_d;
            if (wr_en) fb_q[wr_idx] <= wr_val;
        end
    end

    assign o_Step = step_q;

    for (genvar s = 0; s < 8; s++) begin : g_row
        for (genvar r = 0; r < DISP_ROWS; r++) begin : g_mrow
            for (genvar c = 0; c < DISP_COLUMNS; c++) begin : g_mcol
                assign o_MAX7219_DataStream[7-s][r][c] =
                    {HDR, reg_row(s), fb_q[((r * 8 + 7 - s) * FB_W + c * 8) +: 8]};
            end
        end
    end

endmodule

// File: tb/tb_pattern_multi_snake.sv
// Directed bench for pattern_multi_snake: three configurations (bounce, wrap,
// two snakes on a 2x1 grid) checked against hand-computed frames and timing.
module tb_pattern_multi_snake;
    import max7219_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic pause_a = 1'b0, pause_b = 1'b0, pause_c = 1'b0;
    logic stp_a, stp_b, stp_c;
    logic [0:7][0:0][0:0][15:0] ds_a, ds_b;
    logic [0:7][1:0][0:0][15:0] ds_c;

    int n_checks = 0;
    int n_errors = 0;

    pattern_multi_snake #(
        .DISP_ROWS(1), .DISP_COLUMNS(1), .DELAY_CLOCKS(3),
        .NUM_SNAKES(1), .TAIL_LENGTH(2), .EDGE_MODE(EDGE_BOUNCE)
    ) u_a (
        .i_Clk(clk), .i_Rst(rst_a), .i_Pause(pause_a),
        .o_Step(stp_a), .o_MAX7219_DataStream(ds_a)
    );

    pattern_multi_snake #(
        .DISP_ROWS(1), .DISP_COLUMNS(1), .DELAY_CLOCKS(3),
        .NUM_SNAKES(1), .TAIL_LENGTH(2), .EDGE_MODE(EDGE_WRAP)
    ) u_b (
        .i_Clk(clk), .i_Rst(rst_b), .i_Pause(pause_b),
        .o_Step(stp_b), .o_MAX7219_DataStream(ds_b)
    );

    pattern_multi_snake #(
        .DISP_ROWS(2), .DISP_COLUMNS(1), .DELAY_CLOCKS(5),
        .NUM_SNAKES(2), .TAIL_LENGTH(0), .EDGE_MODE(EDGE_BOUNCE)
    ) u_c (
        .i_Clk(clk), .i_Rst(rst_c), .i_Pause(pause_c),
        .o_Step(stp_c), .o_MAX7219_DataStream(ds_c)
    );

    // Frames flattened as bit y*8+x for pixel (x,y).
    logic [63:0]  fa, fw;
    logic [127:0] fc;
    always_comb begin
        fa = '0;
        fw = '0;
        fc = '0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                fa[y*8+x] = ds_a[y][0][0][x];
                fw[y*8+x] = ds_b[y][0][0][x];
            end
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 8; x++)
                fc[y*8+x] = ds_c[y%8][y/8][0][x];
    end

    logic stp [3];
    assign stp[0] = stp_a;
    assign stp[1] = stp_b;
    assign stp[2] = stp_c;

    logic [15:0] exp_w [8] = '{16'h0800, 16'h0700, 16'h0600, 16'h0500,
                               16'h0400, 16'h0300, 16'h0200, 16'h0100};
    logic [7:0] a_diag [18] = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC0,
                                8'hA0, 8'h30, 8'h38, 8'h1C, 8'h0E, 8'h07, 8'h03, 8'h05, 8'h0C};
    logic [7:0] b_diag [10] = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h1C,
                                8'h38, 8'h70, 8'hE0, 8'hC1, 8'h83};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] px(input int x, input int y);
        logic [127:0] m;
        m = '0;
        m[y*8+x] = 1'b1;
        return m;
    endfunction

    function automatic logic [127:0] diag_frame(input logic [7:0] mask);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < 8; i++)
            if (mask[i]) m = m | px(i, i);
        return m;
    endfunction

    task automatic wait_step(input int idx, input int budget, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            seen = stp[idx];
        end
        check("step_seen", 128'(seen), 128'(1'b1));
    endtask

    task automatic do_step(input int idx, input int exp_lat, input logic [127:0] exp_frame,
                           input string tag);
        int lat;
        logic [127:0] got;
        wait_step(idx, 60, lat);
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        case (idx)
            0:       got = {64'd0, fa};
            1:       got = {64'd0, fw};
            default: got = fc;
        endcase
        check({tag, "_fb"}, got, exp_frame);
    endtask

    initial begin
        logic [63:0] snap;
        int bad;

        // Single bounce snake: reset state, fill, tail erase, corner bounce, pause.
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 8; j++)
            check($sformatf("a_rst_w%0d", j), 128'(ds_a[j][0][0]), 128'(exp_w[j]));
        check("a_rst_step", 128'(stp_a), 128'(1'b0));
        for (int n = 0; n < 17; n++)
            do_step(0, 6, diag_frame(a_diag[n]), $sformatf("a_step%0d", n + 1));

        snap = fa;
        bad  = 0;
        @(posedge clk);
        #1 pause_a = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (stp_a || fa !== snap) bad++;
            @(posedge clk);
        end
        #1 pause_a = 1'b0;
        check("a_pause_frozen", 128'(bad), 128'(0));
        do_step(0, 6, diag_frame(a_diag[17]), "a_step18");

        // Wrap snake: (7,7) is followed by (0,0) and both stay lit.
        @(posedge clk);
        #1 rst_b = 1'b0;
        @(negedge clk);
        check("b_rst_fb", {64'd0, fw}, 128'd0);
        for (int n = 0; n < 10; n++)
            do_step(1, 6, diag_frame(b_diag[n]), $sformatf("b_step%0d", n + 1));

        // Two snakes on 2x1: period, tail-vs-head priority, mid-step reset.
        @(posedge clk);
        #1 rst_c = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 8; j++)
            for (int r = 0; r < 2; r++)
                check($sformatf("c_rst_w%0d_%0d", j, r), 128'(ds_c[j][r][0]), 128'(exp_w[j]));
        check("c_rst_step", 128'(stp_c), 128'(1'b0));
        do_step(2, 10, px(0, 0) | px(3, 1), "c_step1");
        do_step(2, 10, px(1, 1) | px(2, 2), "c_step2");
        do_step(2, 10, px(2, 2) | px(1, 3), "c_step3");

        repeat (9) @(posedge clk);
        #1 rst_c = 1'b1;
        @(negedge clk);
        check("c_mid_plot_fb", fc, px(3, 3));
        @(posedge clk);
        #1 rst_c = 1'b0;
        @(negedge clk);
        check("c_abort_fb", fc, 128'd0);
        check("c_abort_step", 128'(stp_c), 128'(1'b0));
        check("c_abort_w0", 128'(ds_c[0][1][0]), 128'(exp_w[0]));
        do_step(2, 10, px(0, 0) | px(3, 1), "c_restart");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
